// File: rtl/jelly2_jfive_wb_uart_pkg.sv
// Shared register map, status bit positions and shifter states for the jfive WISHBONE UART transmitter.
package jelly2_jfive_wb_uart_pkg;

  localparam logic [1:0] ADR_TX_DATA = 2'd0;
  localparam logic [1:0] ADR_STATUS  = 2'd1;
  localparam logic [1:0] ADR_DIVIDER = 2'd2;
  localparam logic [1:0] ADR_CONTROL = 2'd3;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/jelly2_jfive_wb_uart_tx_if.sv
// WISHBONE slave bus bundle between the jfive m_wb port and the UART transmitter.
interface jelly2_jfive_wb_uart_tx_if #(
  parameter int ADR_WIDTH = 16
);
  logic [ADR_WIDTH-1:0] s_wb_adr_i;
  logic [31:0]          s_wb_dat_i;
  logic [31:0]          s_wb_dat_o;
  logic [3:0]           s_wb_sel_i;
  logic                 s_wb_we_i;
  logic                 s_wb_stb_i;
  logic                 s_wb_ack_o;

  modport master (
    output s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_stb_i,
    input  s_wb_dat_o, s_wb_ack_o
  );

  modport slave (
    input  s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_stb_i,
    output s_wb_dat_o, s_wb_ack_o
  );
endinterface

// File: rtl/jelly2_jfive_uart_tx_fifo.sv
// Byte FIFO feeding the UART shifter; flush wins over push, full drops pushes even when popping.
module jelly2_jfive_uart_tx_fifo #(
  parameter int PTR_WIDTH = 4
) (
  input  logic               reset,
  input  logic               clk,
  input  logic               cke,
  input  logic               push,
  input  logic [7:0]         push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [7:0]         pop_data,
  output logic               full,
  output logic               empty,
  output logic [PTR_WIDTH:0] count
);
  localparam int DEPTH = 2 ** PTR_WIDTH;

  logic [7:0]           mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == (PTR_WIDTH+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = cke & push & ~full & ~flush;
  assign do_pop   = cke & pop & ~empty & ~flush;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (cke) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: rtl/jelly2_jfive_wb_uart_tx.sv
// WISHBONE-mapped 8N1 UART transmitter: register file, TX FIFO and baud-divided shifter.
module jelly2_jfive_wb_uart_tx
  import jelly2_jfive_wb_uart_pkg::*;
#(
  parameter int                      ADR_WIDTH      = 16,
  parameter int                      FIFO_PTR_WIDTH = 4,
  parameter int                      DIVIDER_WIDTH  = 16,
  parameter logic [DIVIDER_WIDTH-1:0] INIT_DIVIDER  = 16'd867,
  parameter logic                    INIT_ENABLE    = 1'b1
) (
  input  logic                      reset,
  input  logic                      clk,
  input  logic                      cke,
  jelly2_jfive_wb_uart_tx_if.slave  s_wb,
  output logic                      uart_tx,
  output logic                      irq
);
  localparam int CNT_WIDTH = FIFO_PTR_WIDTH + 1;

  logic [1:0]               reg_adr;
  logic                     wr_en;
  logic                     push_req;
  logic                     ovf_clr;
  logic                     flush;
  logic [31:0]              lane_mask;
  logic [DIVIDER_WIDTH-1:0] divider;
  logic                     enable;
  logic                     overflow;
  logic [7:0]               pop_data;
  logic                     full;
  logic                     empty;
  logic [CNT_WIDTH-1:0]     count;
  logic                     pop;
  logic                     start_next;
  logic                     baud_end;
  tx_state_t                state;
  logic [7:0]               shreg;
  logic [2:0]               bit_cnt;
  logic [DIVIDER_WIDTH-1:0] baud_cnt;
  logic [31:0]              status;
  logic                     unused_bits;

  assign reg_adr   = s_wb.s_wb_adr_i[1:0];
  assign wr_en     = s_wb.s_wb_stb_i & s_wb.s_wb_we_i & cke;
  assign push_req  = wr_en & (reg_adr == ADR_TX_DATA) & s_wb.s_wb_sel_i[0];
  assign ovf_clr   = wr_en & (reg_adr == ADR_STATUS) & s_wb.s_wb_sel_i[0] & s_wb.s_wb_dat_i[STAT_OVERFLOW];
  assign flush     = wr_en & (reg_adr == ADR_CONTROL) & s_wb.s_wb_sel_i[0] & s_wb.s_wb_dat_i[CTRL_FLUSH];
  assign lane_mask = {{8{s_wb.s_wb_sel_i[3]}}, {8{s_wb.s_wb_sel_i[2]}},
                      {8{s_wb.s_wb_sel_i[1]}}, {8{s_wb.s_wb_sel_i[0]}}};
  assign s_wb.s_wb_ack_o = s_wb.s_wb_stb_i & cke;
  assign unused_bits = ^{s_wb.s_wb_adr_i[ADR_WIDTH-1:2], s_wb.s_wb_dat_i[31:DIVIDER_WIDTH], lane_mask[31:DIVIDER_WIDTH]};

  jelly2_jfive_uart_tx_fifo #(
    .PTR_WIDTH (FIFO_PTR_WIDTH)
  ) u_fifo (
    .reset     (reset),
    .clk       (clk),
    .cke       (cke),
    .push      (push_req),
    .push_data (s_wb.s_wb_dat_i[7:0]),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // A rejected push sets overflow even if firmware clears it in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      divider  <= INIT_DIVIDER;
      enable   <= INIT_ENABLE;
      overflow <= 1'b0;
    end else if (cke) begin
      if (wr_en && reg_adr == ADR_DIVIDER) begin
        divider <= (divider & ~lane_mask[DIVIDER_WIDTH-1:0])
                 | (s_wb.s_wb_dat_i[DIVIDER_WIDTH-1:0] & lane_mask[DIVIDER_WIDTH-1:0]);
      end
      if (wr_en && reg_adr == ADR_CONTROL && s_wb.s_wb_sel_i[0]) begin
        enable <= s_wb.s_wb_dat_i[CTRL_ENABLE];
      end
      if (push_req && full && !flush) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign start_next = enable & ~empty;
  assign baud_end   = (baud_cnt == divider);
  assign pop        = cke & start_next & ((state == IDLE) | ((state == STOP) & baud_end));

  // STOP chains straight into the next start bit so queued bytes go out without an idle gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else if (cke) begin
      case (state)
        IDLE: begin
          if (start_next) begin
            shreg    <= pop_data;
            uart_tx  <= 1'b0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            uart_tx  <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + DIVIDER_WIDTH'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              uart_tx <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + DIVIDER_WIDTH'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (start_next) begin
              shreg   <= pop_data;
              uart_tx <= 1'b0;
              bit_cnt <= '0;
              state   <= START;
            end else begin
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + DIVIDER_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign irq = empty & (state == IDLE);

  always_comb begin
    status                                 = '0;
    status[STAT_FULL]                      = full;
    status[STAT_EMPTY]                     = empty;
    status[STAT_BUSY]                      = (state != IDLE);
    status[STAT_OVERFLOW]                  = overflow;
    status[STAT_COUNT_LSB +: CNT_WIDTH]    = count;
  end

  always_comb begin
    s_wb.s_wb_dat_o = '0;
    case (reg_adr)
      ADR_STATUS:  s_wb.s_wb_dat_o = status;
      ADR_DIVIDER: s_wb.s_wb_dat_o[DIVIDER_WIDTH-1:0] = divider;
      ADR_CONTROL: s_wb.s_wb_dat_o[CTRL_ENABLE] = enable;
      default:     s_wb.s_wb_dat_o = '0;
    endcase
  end
endmodule

// File: tb/tb_jelly2_jfive_wb_uart_tx.sv
// Directed bench for the WISHBONE UART transmitter: register access, frame timing, FIFO limits, reset and cke.
module tb_jelly2_jfive_wb_uart_tx;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic cke   = 1'b1;
  logic uart_tx;
  logic irq;
  int   checks = 0;
  int   errors = 0;

  jelly2_jfive_wb_uart_tx_if #(.ADR_WIDTH(16)) wb ();

  jelly2_jfive_wb_uart_tx dut (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
    .s_wb    (wb),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One acked write; returns 1ns after the edge that commits it.
  task automatic applyStimulus(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb.s_wb_adr_i = {14'd0, adr};
    wb.s_wb_dat_i = dat;
    wb.s_wb_sel_i = sel;
    wb.s_wb_we_i  = 1'b1;
    wb.s_wb_stb_i = 1'b1;
    @(posedge clk);
    #1;
    wb.s_wb_stb_i = 1'b0;
    wb.s_wb_we_i  = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb.s_wb_adr_i = {14'd0, adr};
    wb.s_wb_we_i  = 1'b0;
    wb.s_wb_stb_i = 1'b1;
    #2;
    rd = wb.s_wb_dat_o;
    wb.s_wb_stb_i = 1'b0;
    checkOutput(tag, {32'd0, rd}, {32'd0, exp});
  endtask

  task automatic capture(input int n, output logic [63:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v[i] = uart_tx;
      @(posedge clk);
      #1;
    end
  endtask

  // Line level k cycles after a start bit, for nbytes back-to-back frames, idle high afterwards.
  function automatic logic frame_bit(input int k, input int div, input logic [23:0] bytes, input int nbytes);
    int f;
    int j;
    f = k / (10 * (div + 1));
    if (f >= nbytes) return 1'b1;
    j = (k / (div + 1)) % 10;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return bytes[8*f + j - 1];
  endfunction

  function automatic logic [63:0] expect_frames(input int first, input int n, input int div,
                                                 input logic [23:0] bytes, input int nbytes);
    logic [63:0] e;
    e = '0;
    for (int i = 0; i < n; i++) e[i] = frame_bit(first + i, div, bytes, nbytes);
    return e;
  endfunction

  initial begin
    logic [63:0] v;
    logic [63:0] e;

    wb.s_wb_adr_i = '0;
    wb.s_wb_dat_i = '0;
    wb.s_wb_sel_i = '0;
    wb.s_wb_we_i  = 1'b0;
    wb.s_wb_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("reset uart_tx", {63'd0, uart_tx}, 64'd1);
    checkOutput("reset irq", {63'd0, irq}, 64'd1);
    check_reg("reset status", 2'd1, 32'h0000_0002);
    check_reg("reset divider", 2'd2, 32'd867);
    check_reg("reset control", 2'd3, 32'h1);
    check_reg("tx_data reads 0", 2'd0, 32'h0);

    $display("[TB] single 0xA5 frame, divider 3");
    applyStimulus(2'd2, 32'd3, 4'b0011);
    check_reg("divider 3", 2'd2, 32'd3);
    applyStimulus(2'd0, 32'hA5, 4'b0001);
    @(posedge clk);
    #1;
    capture(20, v);
    checkOutput("frame A5 head", v, expect_frames(0, 20, 3, 24'h0000A5, 1));
    check_reg("busy mid frame", 2'd1, 32'h0000_0006);
    capture(20, v);
    checkOutput("frame A5 tail", v, expect_frames(20, 20, 3, 24'h0000A5, 1));
    checkOutput("irq after A5", {63'd0, irq}, 64'd1);
    check_reg("idle after A5", 2'd1, 32'h0000_0002);

    $display("[TB] three back-to-back frames, divider 0");
    applyStimulus(2'd2, 32'd0, 4'b0011);
    applyStimulus(2'd3, 32'd0, 4'b0001);
    applyStimulus(2'd0, 32'h01, 4'b0001);
    applyStimulus(2'd0, 32'h02, 4'b0001);
    applyStimulus(2'd0, 32'h03, 4'b0001);
    check_reg("count 3 disabled", 2'd1, 32'h0000_0300);
    applyStimulus(2'd3, 32'd1, 4'b0001);
    @(posedge clk);
    #1;
    check_reg("count 2 after pop", 2'd1, 32'h0000_0204);
    capture(30, v);
    checkOutput("frames 01 02 03", v, expect_frames(0, 30, 0, 24'h030201, 3));
    checkOutput("irq after burst", {63'd0, irq}, 64'd1);

    $display("[TB] overflow, clear and flush");
    applyStimulus(2'd3, 32'd0, 4'b0001);
    for (int i = 0; i < 17; i++) applyStimulus(2'd0, 32'(i), 4'b0001);
    check_reg("full overflow", 2'd1, 32'h0000_1009);
    check_reg("control disabled", 2'd3, 32'h0);
    applyStimulus(2'd1, 32'h8, 4'b0001);
    check_reg("overflow cleared", 2'd1, 32'h0000_1001);
    applyStimulus(2'd3, 32'h2, 4'b0001);
    check_reg("flushed", 2'd1, 32'h0000_0002);
    check_reg("flush reads 0", 2'd3, 32'h0);
    checkOutput("irq after flush", {63'd0, irq}, 64'd1);

    $display("[TB] disable mid frame");
    applyStimulus(2'd2, 32'd3, 4'b0011);
    applyStimulus(2'd0, 32'h55, 4'b0001);
    applyStimulus(2'd0, 32'h66, 4'b0001);
    applyStimulus(2'd3, 32'd1, 4'b0001);
    @(posedge clk);
    #1;
    capture(11, v);
    checkOutput("frame 55 head", v, expect_frames(0, 11, 3, 24'h000055, 1));
    applyStimulus(2'd3, 32'd0, 4'b0001);
    capture(36, v);
    checkOutput("frame 55 tail then idle", v, expect_frames(12, 36, 3, 24'h000055, 1));
    check_reg("66 still queued", 2'd1, 32'h0000_0100);
    checkOutput("irq low with queued byte", {63'd0, irq}, 64'd0);
    applyStimulus(2'd3, 32'd1, 4'b0001);
    @(posedge clk);
    #1;
    capture(40, v);
    checkOutput("frame 66 after enable", v, expect_frames(0, 40, 3, 24'h000066, 1));
    checkOutput("irq after 66", {63'd0, irq}, 64'd1);

    $display("[TB] reset during data bit 4");
    applyStimulus(2'd0, 32'h0F, 4'b0001);
    repeat (22) @(posedge clk);
    #1;
    checkOutput("bit4 of 0F", {63'd0, uart_tx}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("uart_tx after reset", {63'd0, uart_tx}, 64'd1);
    reset = 1'b0;
    check_reg("status after reset", 2'd1, 32'h0000_0002);
    check_reg("divider after reset", 2'd2, 32'd867);
    check_reg("control after reset", 2'd3, 32'h1);
    checkOutput("irq after reset", {63'd0, irq}, 64'd1);

    $display("[TB] cke hold stretches start bit");
    applyStimulus(2'd2, 32'd3, 4'b0011);
    wb.s_wb_adr_i = 16'd1;
    wb.s_wb_stb_i = 1'b1;
    #1;
    checkOutput("ack with cke", {63'd0, wb.s_wb_ack_o}, 64'd1);
    wb.s_wb_stb_i = 1'b0;
    applyStimulus(2'd0, 32'h0F, 4'b0001);
    @(posedge clk);
    #1;
    v = '0;
    for (int i = 0; i < 45; i++) begin
      v[i] = uart_tx;
      if (i == 1) begin
        cke = 1'b0;
        wb.s_wb_adr_i = 16'd0;
        wb.s_wb_dat_i = 32'hEE;
        wb.s_wb_sel_i = 4'b0001;
        wb.s_wb_we_i  = 1'b1;
        wb.s_wb_stb_i = 1'b1;
      end
      if (i == 3) begin
        #1;
        checkOutput("ack without cke", {63'd0, wb.s_wb_ack_o}, 64'd0);
      end
      if (i == 6) begin
        wb.s_wb_stb_i = 1'b0;
        wb.s_wb_we_i  = 1'b0;
        cke = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    e = '0;
    for (int k = 0; k < 45; k++) e[k] = (k < 9) ? 1'b0 : frame_bit(k - 5, 3, 24'h00000F, 1);
    checkOutput("stretched frame", v, e);
    checkOutput("irq after stretch", {63'd0, irq}, 64'd1);
    check_reg("no push while cke low", 2'd1, 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
